// File: rtl/mfp_spi_sensor_responder_pkg.sv
// mfp_spi_sensor_responder_pkg: shared FSM encoding and default frame geometry
package mfp_spi_sensor_responder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, TAIL = 2'd2} state_t;
    localparam int FRAME_BITS_D  = 16;
    localparam int LEAD_ZEROS_D  = 3;
    localparam int DATA_WIDTH_D  = 8;
    localparam int SYNC_STAGES_D = 2;
endpackage

// File: rtl/mfp_spi_sensor_responder_sync.sv
// mfp_sync_cell: flop-chain synchroniser with selectable reset level
// Ports: HCLK/HRESETn clock and async active-low reset, d async input, q synchronised output.
module mfp_sync_cell
    import mfp_spi_sensor_responder_pkg::*;
#(
    parameter int   STAGES  = SYNC_STAGES_D,
    parameter logic RST_VAL = 1'b0
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] s;
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) s <= {STAGES{RST_VAL}};
        else          s <= {s[STAGES-2:0], d};
    assign q = s[STAGES-1];
endmodule

// File: rtl/mfp_spi_sensor_responder.sv
// mfp_spi_sensor_responder: SPI responder serialising a host-loaded ADC sample
// Ports: HCLK/HRESETn clock and async active-low reset; sample_in/sample_load load the pending sample;
// spi_cs_n/spi_sck from the master (async); spi_sdo/spi_sdo_oe serial data and enable;
// busy frame active; frame_done/frame_abort one-cycle pulses; extra_clk sticky overrun flag.
module mfp_spi_sensor_responder
    import mfp_spi_sensor_responder_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_D,
    parameter int LEAD_ZEROS  = LEAD_ZEROS_D,
    parameter int DATA_WIDTH  = DATA_WIDTH_D,
    parameter int SYNC_STAGES = SYNC_STAGES_D
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_load,
    input  logic                  spi_cs_n,
    input  logic                  spi_sck,
    output logic                  spi_sdo,
    output logic                  spi_sdo_oe,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic                  extra_clk
);
    localparam int TRAIL = FRAME_BITS - LEAD_ZEROS - DATA_WIDTH;
    localparam int CW    = $clog2(FRAME_BITS + 1);
    localparam int FW    = $clog2(SYNC_STAGES + 1);
    state_t                state, next_state;
    logic                  cs_s, cs_d, sck_s, sck_d, armed;
    logic [FW-1:0]         flush_q;
    logic [DATA_WIDTH-1:0] pending, load_val;
    logic [FRAME_BITS-1:0] shift_q;
    logic [CW-1:0]         bit_cnt;
    logic                  cs_fall, cs_rise, sck_fall, full, flushed;
    mfp_sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs  (.HCLK(HCLK), .HRESETn(HRESETn), .d(spi_cs_n), .q(cs_s));
    mfp_sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (.HCLK(HCLK), .HRESETn(HRESETn), .d(spi_sck),  .q(sck_s));
    // A chip select already low when reset ends must not start a frame: arming
    // waits until the flushed synchroniser has shown CS_n high at least once.
    assign flushed  = flush_q == FW'(SYNC_STAGES);
    assign cs_fall  = armed & cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_fall = sck_d & ~sck_s;
    assign full     = bit_cnt == CW'(FRAME_BITS);
    assign load_val = sample_load ? sample_in : pending;
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) state <= IDLE;
        else          state <= next_state;
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = cs_fall ? SHIFT : IDLE;
            SHIFT:   next_state = cs_rise ? IDLE : (full ? TAIL : SHIFT);
            TAIL:    next_state = cs_rise ? IDLE : TAIL;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        spi_sdo_oe = state != IDLE;
        busy       = state != IDLE;
        spi_sdo    = (state == SHIFT) & shift_q[FRAME_BITS-1];
    end
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            cs_d        <= 1'b1;
            sck_d       <= 1'b0;
            flush_q     <= '0;
            armed       <= 1'b0;
            pending     <= '0;
            shift_q     <= '0;
            bit_cnt     <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            extra_clk   <= 1'b0;
        end else begin
            cs_d        <= cs_s;
            sck_d       <= sck_s;
            flush_q     <= flushed ? flush_q : flush_q + FW'(1);
            armed       <= armed | (flushed & cs_s);
            pending     <= load_val;
            frame_done  <= cs_rise & ((state == TAIL) | ((state == SHIFT) & full));
            frame_abort <= cs_rise & (state == SHIFT) & ~full;
            // CS_n fall wins over a coincident SCK fall, which is dropped.
            if ((state == IDLE) & cs_fall) begin
                shift_q   <= {{LEAD_ZEROS{1'b0}}, load_val, {TRAIL{1'b0}}};
                bit_cnt   <= '0;
                extra_clk <= 1'b0;
            end else if ((state == SHIFT) & cs_rise) begin
                shift_q <= '0;
            end else if ((state == SHIFT) & sck_fall & ~full) begin
                shift_q <= shift_q << 1;
                bit_cnt <= bit_cnt + CW'(1);
            end
            if ((state == TAIL) & sck_fall) extra_clk <= 1'b1;
        end
endmodule
